ask_frame_scheduler: RTL and testbench
======================================

Name: ask_frame_scheduler

Overview:
- Sequences the 4-ASK PWM modulator for framed transmission.
- Per frame: emits PRE_LEN preamble bytes, then frame_len payload bytes pulled from an upstream valid/ready byte source, then a silent gap.
- Drives the modulator's sampler byte and Allow enable, and generates the symbol-rate clock/tick from the 50 MHz system clock, replacing the separate 800 Hz source.

Parameters:
- SYM_DIV, 62500: clk cycles per 2-bit symbol. Must be even and at least 2; 62500 gives 800 Hz at 50 MHz.
- PRE_LEN, 2: preamble byte count. Range 1..15.
- PREAMBLE, 8'hAA: preamble byte value.
- GAP_CYC, 16000: cycles with Allow low after each frame. Must be at least 1.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  frame request; sampled in IDLE only.
- frame_len  in  8  payload byte count; latched on accepted start.
- in_data  in  8  payload byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  scheduler takes in_data this cycle if in_valid=1.
- sampler  out  8  byte to modulator; 4 symbols of 2 bits each.
- Allow  out  1  modulator enable; high while transmitting.
- sym_clk  out  1  symbol-rate square wave to modulator.
- sym_tick  out  1  one-cycle pulse at the end of each symbol.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a frame ends; normal or truncated.
- underrun  out  1  one-cycle pulse when payload is missing at a byte boundary.

Behaviour:
- Reset (rst=0):
  - Asynchronous, effective at any time including mid-frame.
  - State goes to IDLE; all counters clear.
  - sampler=0, Allow=0, in_ready=0, sym_clk=0, sym_tick=0, busy=0, done=0, underrun=0.
- States: IDLE, PRE, PAY, GAP. All outputs are registered except in_ready.
- in_ready is decoded combinationally from state and counters only; it never depends on in_valid.
- Symbol timing:
  - div counts 0..SYM_DIV-1 only in PRE and PAY; it is held at 0 elsewhere.
  - sym_tick=1 when div==SYM_DIV-1.
  - sym_cnt (2 bits) increments on each tick and wraps 3→0.
  - byte_end = sym_tick && sym_cnt==3. Each byte therefore lasts exactly 4*SYM_DIV cycles.
  - sym_clk=1 while div<SYM_DIV/2 in PRE or PAY; sym_clk=0 otherwise.
- IDLE:
  - start=1 with frame_len!=0 is accepted: latch len.
  - Next cycle: state=PRE, Allow=1, busy=1, sampler=PREAMBLE, div=0, sym_cnt=0, pre_cnt=0.
  - start with frame_len=0 is ignored; no busy, no done.
- start outside IDLE is ignored.
- PRE:
  - On byte_end with pre_cnt<PRE_LEN-1: pre_cnt++, sampler stays PREAMBLE.
  - On byte_end with pre_cnt==PRE_LEN-1: in_ready=1 that cycle.
    - If in_valid=1: sampler<=in_data, bytes_left<=len-1, state=PAY.
    - Else: underrun path.
- PAY:
  - On byte_end with bytes_left!=0: in_ready=1.
    - If in_valid=1: sampler<=in_data, bytes_left--.
    - Else: underrun path.
  - On byte_end with bytes_left==0: enter GAP.
- Underrun path: underrun=1 for one cycle (the cycle after the failed byte_end), then enter GAP. The frame is truncated and the byte is not consumed.
- Entering GAP (registered on the byte_end edge): Allow=0, sampler=0, gap_cnt=0.
- GAP:
  - Count GAP_CYC cycles.
  - On the last count: done=1 for one cycle, then state=IDLE, busy=0.
- in_ready is 0 in all other cycles. in_data is consumed only when in_ready && in_valid.
- Counter widths are sized from parameters via clog2, with no truncation. bytes_left is 8-bit; len=255 gives 255 payload bytes.

Test Plan:
- Common bench parameters: SYM_DIV=4, PRE_LEN=2, GAP_CYC=8, PREAMBLE=AA.
- Reset: assert rst=0 mid-clock-cycle → all outputs 0 immediately, with no clock edge required.
- Normal frame: start with frame_len=2; in_valid=1 with data E4, then 1B →
  - busy and Allow rise 1 cycle after start.
  - sampler=AA for 32 cycles.
  - in_ready pulses on cycle 32; sampler=E4 for 16 cycles.
  - in_ready pulses again; sampler=1B for 16 cycles.
  - Allow=0 and sampler=0 for 8 cycles; done pulses; busy low after 72 cycles total.
  - Exactly 2 bytes are consumed.
- Underrun: same as the normal frame but in_valid=0 at the first in_ready →
  - underrun pulses once; Allow falls.
  - done follows 8 cycles later.
  - No byte is consumed; sampler never leaves AA/0.
- Ignored starts:
  - start with frame_len=0 → busy stays 0.
  - start=1 held during PAY → no restart; frame timing unchanged.
- Reset mid-PAY: rst=0 for 3 cycles → IDLE with all outputs 0; a following start/frame_len=1 produces a correct 1-byte frame.
- Symbol timing during the normal frame: sym_tick every 4 cycles, 16 ticks per 64-cycle active window; sym_clk pattern 1,1,0,0; sym_clk=0 in GAP and IDLE.

Source files
------------

// File: rtl/ask_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ask_frame_scheduler
// Brief    : Frames preamble + payload bytes for the 4-ASK PWM modulator and
//            derives its symbol clock/tick from the system clock.
// Revision : 1.0 - initial release
// ============================================================================
module ask_frame_scheduler #(
   parameter int         SYM_DIV  = 62500,
   parameter int         PRE_LEN  = 2,
   parameter logic [7:0] PREAMBLE = 8'hAA,
   parameter int         GAP_CYC  = 16000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] frame_len,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] sampler,
   output logic       Allow,
   output logic       sym_clk,
   output logic       sym_tick,
   output logic       busy,
   output logic       done,
   output logic       underrun
);

   localparam int DIV_W = (SYM_DIV > 2) ? $clog2(SYM_DIV) : 1;
   localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

   localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(SYM_DIV - 1);
   localparam logic [DIV_W-1:0] C_DIV_HALF = DIV_W'(SYM_DIV / 2);
   localparam logic [3:0]       C_PRE_LAST = 4'(PRE_LEN - 1);
   localparam logic [GAP_W-1:0] C_GAP_LAST = GAP_W'(GAP_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PRE  = 2'd1,
      S_PAY  = 2'd2,
      S_GAP  = 2'd3
   } state_t;

   state_t           r_state;
   logic [DIV_W-1:0] r_div;
   logic [1:0]       r_sym_cnt;
   logic [3:0]       r_pre_cnt;
   logic [7:0]       r_len;
   logic [7:0]       r_bytes_left;
   logic [GAP_W-1:0] r_gap_cnt;
   logic [7:0]       r_sampler;
   logic             r_allow;
   logic             r_sym_clk;
   logic             r_sym_tick;
   logic             r_busy;
   logic             r_done;
   logic             r_underrun;

   logic             w_byte_end;
   logic             w_last_pre;
   logic             w_more_pay;
   logic             w_in_ready;
   logic             w_enter_gap;
   logic [DIV_W-1:0] w_div_next;

   // r_sym_tick mirrors div==SYM_DIV-1, so it can stand in for the divider compare
   assign w_byte_end  = r_sym_tick && (r_sym_cnt == 2'd3);
   assign w_last_pre  = (r_state == S_PRE) && (r_pre_cnt == C_PRE_LAST);
   assign w_more_pay  = (r_state == S_PAY) && (r_bytes_left != 8'd0);
   assign w_in_ready  = w_byte_end && (w_last_pre || w_more_pay);
   assign w_enter_gap = w_byte_end &&
                        (((r_state == S_PAY) && (r_bytes_left == 8'd0)) ||
                         (w_in_ready && !in_valid));
   assign w_div_next  = (r_div == C_DIV_LAST) ? '0 : r_div + 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_div        <= '0;
         r_sym_cnt    <= 2'd0;
         r_pre_cnt    <= 4'd0;
         r_len        <= 8'd0;
         r_bytes_left <= 8'd0;
         r_gap_cnt    <= '0;
         r_sampler    <= 8'd0;
         r_allow      <= 1'b0;
         r_sym_clk    <= 1'b0;
         r_sym_tick   <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_underrun   <= 1'b0;
      end else begin
         r_done     <= 1'b0;
         r_underrun <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start && (frame_len != 8'd0)) begin
                  r_len      <= frame_len;
                  r_state    <= S_PRE;
                  r_allow    <= 1'b1;
                  r_busy     <= 1'b1;
                  r_sampler  <= PREAMBLE;
                  r_div      <= '0;
                  r_sym_cnt  <= 2'd0;
                  r_pre_cnt  <= 4'd0;
                  r_sym_tick <= 1'b0;
                  r_sym_clk  <= 1'b1;
               end
            end
            S_PRE, S_PAY: begin
               // tick/clk are registered from the next divider value so they line up with div
               r_div      <= w_div_next;
               r_sym_tick <= (w_div_next == C_DIV_LAST);
               r_sym_clk  <= (w_div_next < C_DIV_HALF);
               if (r_sym_tick) begin
                  r_sym_cnt <= r_sym_cnt + 2'd1;
               end
               if (w_byte_end && (r_state == S_PRE) && !w_last_pre) begin
                  r_pre_cnt <= r_pre_cnt + 4'd1;
               end
               if (w_in_ready && in_valid) begin
                  r_sampler    <= in_data;
                  r_state      <= S_PAY;
                  r_bytes_left <= (r_state == S_PRE) ? (r_len - 8'd1)
                                                     : (r_bytes_left - 8'd1);
               end
               if (w_enter_gap) begin
                  r_underrun <= w_in_ready;
                  r_state    <= S_GAP;
                  r_allow    <= 1'b0;
                  r_sampler  <= 8'd0;
                  r_gap_cnt  <= '0;
                  r_div      <= '0;
                  r_sym_cnt  <= 2'd0;
                  r_sym_tick <= 1'b0;
                  r_sym_clk  <= 1'b0;
               end
            end
            S_GAP: begin
               if (r_gap_cnt == C_GAP_LAST) begin
                  r_gap_cnt <= '0;
                  r_done    <= 1'b1;
                  r_busy    <= 1'b0;
                  r_state   <= S_IDLE;
               end else begin
                  r_gap_cnt <= r_gap_cnt + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready = w_in_ready;
   assign sampler  = r_sampler;
   assign Allow    = r_allow;
   assign sym_clk  = r_sym_clk;
   assign sym_tick = r_sym_tick;
   assign busy     = r_busy;
   assign done     = r_done;
   assign underrun = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_ask_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ask_frame_scheduler
// Brief    : Randomized frame scenarios checked cycle by cycle against a
//            timeline model of the frame schedule.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ask_frame_scheduler;

   localparam int         SYM_DIV  = 4;
   localparam int         PRE_LEN  = 2;
   localparam logic [7:0] PREAMBLE = 8'hAA;
   localparam int         GAP_CYC  = 8;
   localparam int         BYTE_CYC = 4 * SYM_DIV;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] frame_len;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] sampler;
   logic       Allow;
   logic       sym_clk;
   logic       sym_tick;
   logic       busy;
   logic       done;
   logic       underrun;

   int n_checks = 0;
   int n_errors = 0;

   ask_frame_scheduler #(
      .SYM_DIV  (SYM_DIV),
      .PRE_LEN  (PRE_LEN),
      .PREAMBLE (PREAMBLE),
      .GAP_CYC  (GAP_CYC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .frame_len (frame_len),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sampler   (sampler),
      .Allow     (Allow),
      .sym_clk   (sym_clk),
      .sym_tick  (sym_tick),
      .busy      (busy),
      .done      (done),
      .underrun  (underrun)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Runs one frame from IDLE (called at a negedge) and checks every cycle up to
   // and including the done cycle against the frame timeline.
   task automatic run_frame(input int len, input int underrun_at, input bit hold_start,
                            input logic [7:0] d0, input logic [7:0] d1);
      logic [7:0] data [256];
      int consumed, act, dcyc, k, j, taken;
      bit urun;
      bit e_allow, e_busy, e_tick, e_sclk, e_rdy, e_done, e_urun;
      logic [7:0] e_samp;
      for (int i = 0; i < 256; i++) data[i] = 8'($urandom);
      data[0] = d0;
      data[1] = d1;
      urun     = (underrun_at < len);
      consumed = urun ? underrun_at : len;
      act      = BYTE_CYC * (PRE_LEN + consumed);
      dcyc     = act + GAP_CYC;
      taken    = 0;
      start     = 1'b1;
      frame_len = 8'(len);
      in_valid  = 1'b0;
      @(posedge clk);
      for (int t = 0; t <= dcyc; t++) begin
         @(negedge clk);
         e_allow = 0; e_busy = 0; e_tick = 0; e_sclk = 0; e_rdy = 0;
         e_done = 0; e_urun = 0; e_samp = 8'h00;
         k = t / BYTE_CYC;
         if (t < act) begin
            e_allow = 1;
            e_busy  = 1;
            e_samp  = (k < PRE_LEN) ? PREAMBLE : data[k - PRE_LEN];
            e_tick  = ((t % SYM_DIV) == SYM_DIV - 1);
            e_sclk  = ((t % SYM_DIV) < SYM_DIV / 2);
            e_rdy   = ((t % BYTE_CYC) == BYTE_CYC - 1) && (k >= PRE_LEN - 1) &&
                      ((k - (PRE_LEN - 1)) < len);
         end else if (t < dcyc) begin
            e_busy = 1;
            e_urun = urun && (t == act);
         end else begin
            e_done = 1;
         end
         n_checks += 8;
         if (Allow !== e_allow) begin n_errors++; $display("FAIL allow t=%0d got %b exp %b", t, Allow, e_allow); end
         if (busy !== e_busy) begin n_errors++; $display("FAIL busy t=%0d got %b exp %b", t, busy, e_busy); end
         if (sampler !== e_samp) begin n_errors++; $display("FAIL sampler t=%0d got %h exp %h", t, sampler, e_samp); end
         if (sym_tick !== e_tick) begin n_errors++; $display("FAIL sym_tick t=%0d got %b exp %b", t, sym_tick, e_tick); end
         if (sym_clk !== e_sclk) begin n_errors++; $display("FAIL sym_clk t=%0d got %b exp %b", t, sym_clk, e_sclk); end
         if (in_ready !== e_rdy) begin n_errors++; $display("FAIL in_ready t=%0d got %b exp %b", t, in_ready, e_rdy); end
         if (done !== e_done) begin n_errors++; $display("FAIL done t=%0d got %b exp %b", t, done, e_done); end
         if (underrun !== e_urun) begin n_errors++; $display("FAIL underrun t=%0d got %b exp %b", t, underrun, e_urun); end
         // drive this cycle's inputs; payload is offered only when the model expects a boundary
         start     = hold_start && (t >= BYTE_CYC * PRE_LEN) && (t < act);
         frame_len = 8'($urandom_range(1, 255));
         if (((t % BYTE_CYC) == BYTE_CYC - 1) && (k >= PRE_LEN - 1) &&
             ((k - (PRE_LEN - 1)) < len) && (t < act)) begin
            j        = k - (PRE_LEN - 1);
            in_valid = (j < underrun_at);
            in_data  = data[j];
         end else begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
         end
         if (in_ready && in_valid) taken++;
      end
      start    = 1'b0;
      in_valid = 1'b0;
      n_checks++;
      if (taken !== consumed) begin
         n_errors++;
         $display("FAIL consumed len=%0d got %0d exp %0d", len, taken, consumed);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; frame_len = 8'd0; in_data = 8'd0; in_valid = 1'b0;
      #3 rst = 1'b0;
      #1;
      n_checks++;
      if ({sampler, Allow, in_ready, sym_clk, sym_tick, busy, done, underrun} !== 15'd0) begin
         n_errors++;
         $display("FAIL reset_async got %h exp 0",
                  {sampler, Allow, in_ready, sym_clk, sym_tick, busy, done, underrun});
      end
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({sampler, Allow, busy, sym_clk} !== 11'd0) begin
         n_errors++;
         $display("FAIL reset_idle got %h exp 0", {sampler, Allow, busy, sym_clk});
      end
   endtask

   task automatic test_normal_frame;
      run_frame(2, 2, 1'b0, 8'hE4, 8'h1B);
   endtask

   task automatic test_underrun;
      run_frame(2, 0, 1'b0, 8'hE4, 8'h1B);
   endtask

   task automatic test_ignored_start;
      start = 1'b1; frame_len = 8'd0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_checks++;
         if ({busy, Allow, sym_clk, done} !== 4'd0) begin
            n_errors++;
            $display("FAIL zero_len_start cyc=%0d got %b exp 0000", i, {busy, Allow, sym_clk, done});
         end
      end
      start = 1'b0;
   endtask

   task automatic test_start_during_pay;
      run_frame(3, 3, 1'b1, 8'($urandom), 8'($urandom));
   endtask

   task automatic test_reset_mid_pay;
      start = 1'b1; frame_len = 8'd4; in_valid = 1'b1; in_data = 8'h5A;
      @(posedge clk);
      @(negedge clk) start = 1'b0;
      repeat (40) @(negedge clk);
      n_checks++;
      if ({busy, Allow} !== 2'b11) begin
         n_errors++;
         $display("FAIL pre_reset_active got %b exp 11", {busy, Allow});
      end
      #1 rst = 1'b0;
      #1;
      n_checks++;
      if ({sampler, Allow, in_ready, sym_clk, sym_tick, busy, done, underrun} !== 15'd0) begin
         n_errors++;
         $display("FAIL reset_mid_pay got %h exp 0",
                  {sampler, Allow, in_ready, sym_clk, sym_tick, busy, done, underrun});
      end
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      run_frame(1, 1, 1'b0, 8'($urandom), 8'($urandom));
   endtask

   task automatic test_back_to_back;
      int len, ua;
      for (int f = 0; f < 6; f++) begin
         len = $urandom_range(1, 5);
         ua  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len) : len;
         run_frame(len, ua, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      end
   endtask

   task automatic test_max_len;
      run_frame(255, 255, 1'b0, 8'($urandom), 8'($urandom));
   endtask

   task automatic test_idle_quiet;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if ({busy, Allow, sym_clk, sym_tick, in_ready} !== 5'd0) begin
            n_errors++;
            $display("FAIL idle_quiet cyc=%0d got %b exp 00000", i, {busy, Allow, sym_clk, sym_tick, in_ready});
         end
      end
   endtask

   initial begin
      test_reset();
      test_normal_frame();
      test_idle_quiet();
      test_underrun();
      test_ignored_start();
      test_start_during_pay();
      test_reset_mid_pay();
      test_back_to_back();
      test_max_len();
      test_idle_quiet();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
